alu_issue_wb: RTL

ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

---
 rtl/alu_issue_wb_if.sv | 19 +
 rtl/alu_issue_wb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_issue_wb_if.sv
// Instruction issue handshake between an upstream producer and alu_issue_wb.
// The producer drives valid/instr; the issue block answers with ready.
interface alu_issue_wb_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;

   modport master (
      output in_valid,
      output in_instr,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_instr,
      output in_ready
   );
endinterface

// File: rtl/alu_issue_wb.sv
// Three-phase issue/writeback sequencer for an external combinational ALU:
// accept an instruction, present operands from a 4x16 register file, then write the result back.
module alu_issue_wb (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_issue_wb_if.slave        if_in,
   input  logic                 i_ld_en,
   input  logic [1:0]           i_ld_addr,
   input  logic [15:0]          i_ld_data,
   input  logic [1:0]           i_rd_addr,
   output logic [15:0]          o_rd_data,
   output logic [15:0]          o_alu_a,
   output logic [15:0]          o_alu_b,
   output logic                 o_alu_c,
   output logic [2:0]           o_alu_opc,
   input  logic [15:0]          i_alu_w,
   input  logic                 i_alu_zero,
   input  logic                 i_alu_neg,
   output logic                 o_flag_z,
   output logic                 o_flag_n,
   output logic                 o_done
);

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e      r_state;
   state_e      w_state_d;
   logic [15:0] r_rf [4];
   // Only the decoded fields [15:6] are kept; the reserved bits never reach state.
   logic [9:0]  r_instr;
   logic [15:0] r_res;
   logic        r_pend_z;
   logic        r_pend_n;
   logic        r_flag_z;
   logic        r_flag_n;
   logic        r_done;

   logic        w_accept;
   logic [2:0]  w_opc;
   logic [1:0]  w_dst;
   logic [1:0]  w_src_a;
   logic [1:0]  w_src_b;
   logic        w_cin;
   logic        w_unused_rsvd;

   assign w_opc   = r_instr[9:7];
   assign w_dst   = r_instr[6:5];
   assign w_src_a = r_instr[4:3];
   assign w_src_b = r_instr[2:1];
   assign w_cin   = r_instr[0];

   assign w_unused_rsvd = ^if_in.in_instr[5:0];

   // Ready is masked by reset so nothing is offered while rst_n is held low.
   assign if_in.in_ready = (r_state == StIdle) && rst_n;
   assign w_accept       = if_in.in_valid && if_in.in_ready;

   always_comb begin
      w_state_d = r_state;
      o_alu_a   = '0;
      o_alu_b   = '0;
      o_alu_c   = 1'b0;
      o_alu_opc = '0;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_d = StExec;
            end
         end
         StExec: begin
            w_state_d = StWb;
            o_alu_a   = r_rf[w_src_a];
            o_alu_b   = r_rf[w_src_b];
            o_alu_c   = w_cin;
            o_alu_opc = w_opc;
         end
         StWb: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_instr  <= '0;
         r_res    <= '0;
         r_pend_z <= 1'b0;
         r_pend_n <= 1'b0;
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
         r_done   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         r_state <= w_state_d;
         r_done  <= 1'b0;
         if (r_state == StIdle) begin
            // A same-edge load lands before the EXEC operand read of the accepted instruction.
            if (i_ld_en) begin
               r_rf[i_ld_addr] <= i_ld_data;
            end
            if (w_accept) begin
               r_instr <= if_in.in_instr[15:6];
            end
         end
         if (r_state == StExec) begin
            r_res    <= i_alu_w;
            r_pend_z <= i_alu_zero;
            r_pend_n <= i_alu_neg;
         end
         if (r_state == StWb) begin
            r_rf[w_dst] <= r_res;
            r_flag_z    <= r_pend_z;
            r_flag_n    <= r_pend_n;
            r_done      <= 1'b1;
         end
      end
   end

   assign o_rd_data = r_rf[i_rd_addr];
   assign o_flag_z  = r_flag_z;
   assign o_flag_n  = r_flag_n;
   assign o_done    = r_done;

endmodule
